gray_seq_monitor: RTL and testbench
===================================

Name: gray_seq_monitor

Overview:
Receiving end of the synchronous Gray-code counter interface. Samples a WIDTH-bit Gray-code stream and converts it to binary. Acquires lock on a consistent up or down count sequence, then flags every illegal step. Sits beside any Gray-coded counter or pointer; used both as an on-chip checker and as a Gray-to-binary consumer.

Parameters:
WIDTH, 4, Gray/binary code width in bits (>=2)
LOCK_COUNT, 2, consecutive legal same-direction steps needed to lock (1..15)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising clk edge resets)
g_in  input  WIDTH  Gray-coded sample, MSB = bit WIDTH-1
g_valid  input  1  g_in valid this cycle
bin_out  output  WIDTH  registered binary equivalent of last valid g_in
bin_valid  output  1  one-cycle pulse, bin_out updated
locked  output  1  high while in TRACK state
dir  output  1  locked direction: 1 = up, 0 = down; meaningful only when locked
step_err  output  1  one-cycle pulse on an illegal step while locked
err_count  output  ERR_CNT_W  saturating count of step_err pulses

Behaviour:
- Reset (rst==0 at edge): state=ACQ, bin_out=0, bin_valid=0, locked=0, dir=0, step_err=0, err_count=0, match_cnt=0, have_prev=0.
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational, registered into bin_out. Latency 1 cycle: sample at edge N appears on bin_out and bin_valid after edge N.
- g_valid=0: no state, prev, or counter change; bin_valid=0, step_err=0. bin_out holds.
- Step classification vs prev (mod 2^WIDTH): UP if b==prev+1; DOWN if b==prev-1; HOLD if b==prev; BAD otherwise. Wrap is legal: 1111->0000 is UP, 0000->1111 is DOWN (WIDTH=4).
- ACQ:
  - First valid sample after reset or after loss: store prev, set have_prev=1, no classification.
  - UP/DOWN matching cand_dir: match_cnt++.
  - UP/DOWN opposite to cand_dir, or first step: cand_dir=step, match_cnt=1.
  - HOLD: no change.
  - BAD: match_cnt=0.
  - When match_cnt reaches LOCK_COUNT: go to TRACK, locked=1, dir=cand_dir. Takes effect the cycle after the locking sample.
  - No step_err in ACQ.
- TRACK:
  - Step equal to dir: OK.
  - HOLD: OK (counter stalled).
  - Reverse step or BAD: step_err=1 for one cycle; err_count+1, saturating at all-ones; next state ACQ; locked=0; match_cnt=0. The offending sample becomes prev (have_prev stays 1).
- prev updates on every valid sample in every state.
- Reset mid-operation: reset wins over any simultaneous g_valid; all state clears.

Optional Feature:
Macro GRAY_MON_HOLD_ERR_EN.
- Defined: HOLD in TRACK is treated as an error (step_err, err_count++, back to ACQ). For free-running sources.
- Undefined: HOLD is tolerated as specified above.
- ACQ behaviour is identical either way.

Decomposition:
- Package gray_mon_pkg: state enum {ACQ, TRACK}; step enum {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_BAD}; function for modular step classification.
- Sub-module gray2bin: purely combinational, parameter WIDTH, ports g and b. Reusable by other Gray-pointer logic.

Test Plan:
- Reset then up sequence 0000,0001,0011,0010 with g_valid=1 every cycle -> bin_out 0,1,2,3 each one cycle after its sample; locked=1 after the 3rd sample (LOCK_COUNT=2); dir=1; err_count=0.
- Locked up, feed 1000 (bin 15) then 0000 -> wrap accepted, step_err=0, bin_out=0.
- Locked up at bin 3 (0010), feed 0111 (bin 5) -> step_err pulses 1 cycle, locked=0 next cycle, err_count=1; then 0101,0100 (6,7) -> relock, dir=1.
- Down sequence 0000,1000,1001,1011 (0,15,14,13) -> locked=1, dir=0; then feed 1001 (14, reverse step) -> step_err=1.
- Repeat 0011 twice while locked -> no error without GRAY_MON_HOLD_ERR_EN; step_err=1 and err_count+1 with it.
- ERR_CNT_W=2: force 5 errors -> err_count saturates at 3. Assert rst=0 mid-TRACK with g_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gray_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_mon_pkg                                                    |
// | Brief    : Shared types and step classification for gray_seq_monitor.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gray_mon_pkg;

    typedef enum logic [0:0] {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } mon_state_e;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_BAD  = 2'd3
    } step_e;

    localparam int C_MAX_WIDTH = 32;

    // Classifies cur relative to prev modulo 2^width, so wrap-around counts as a legal step.
    function automatic step_e classify_step(
        input logic [C_MAX_WIDTH-1:0] prev,
        input logic [C_MAX_WIDTH-1:0] cur,
        input int                     width
    );
        logic [C_MAX_WIDTH-1:0] mask;
        logic [C_MAX_WIDTH-1:0] diff;
        mask = (width >= C_MAX_WIDTH) ? '1
                                      : ((C_MAX_WIDTH'(1) << width) - C_MAX_WIDTH'(1));
        diff = (cur - prev) & mask;
        if (diff == C_MAX_WIDTH'(1))
            return STEP_UP;
        else if (diff == mask)
            return STEP_DOWN;
        else if (diff == '0)
            return STEP_HOLD;
        else
            return STEP_BAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray2bin                                                        |
// | Brief    : Combinational Gray-to-binary converter, WIDTH bits.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    // Each binary bit is the parity of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^g[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/gray_seq_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_seq_monitor                                                |
// | Brief    : Gray-code stream checker: converts to binary, locks onto an     |
// |            up/down count and flags illegal steps. Define                   |
// |            GRAY_MON_HOLD_ERR_EN to treat a repeated value while locked     |
// |            as an error (free-running sources). WIDTH must be 2..32.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gray_seq_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     g_in,
    input  logic                 g_valid,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 locked,
    output logic                 dir,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

`ifdef GRAY_MON_HOLD_ERR_EN
    localparam logic C_HOLD_IS_ERR = 1'b1;
`else
    localparam logic C_HOLD_IS_ERR = 1'b0;
`endif

    mon_state_e           state_q;
    logic [WIDTH-1:0]     prev_q;
    logic                 have_prev_q;
    logic                 cand_dir_q;
    logic [3:0]           match_cnt_q;
    logic [WIDTH-1:0]     bin_out_q;
    logic                 bin_valid_q;
    logic                 locked_q;
    logic                 dir_q;
    logic                 step_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic [WIDTH-1:0]     w_bin;
    step_e                w_step;
    logic                 w_step_up;
    logic                 w_is_move;
    logic [3:0]           match_cnt_d;
    logic                 w_lock;
    logic                 w_track_err;
    logic [ERR_CNT_W-1:0] err_count_d;

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .g (g_in),
        .b (w_bin)
    );

    assign w_step    = classify_step(C_MAX_WIDTH'(prev_q), C_MAX_WIDTH'(w_bin), WIDTH);
    assign w_step_up = (w_step == STEP_UP);
    assign w_is_move = (w_step == STEP_UP) || (w_step == STEP_DOWN);

    // A zero match count means no candidate direction is established yet.
    assign match_cnt_d = ((match_cnt_q != 4'd0) && (w_step_up == cand_dir_q))
                         ? match_cnt_q + 4'd1 : 4'd1;
    assign w_lock      = (match_cnt_d >= 4'(LOCK_COUNT));

    assign w_track_err = (w_step == STEP_BAD)
                      || (w_is_move && (w_step_up != dir_q))
                      || ((w_step == STEP_HOLD) && C_HOLD_IS_ERR);

    assign err_count_d = (err_count_q == '1) ? err_count_q
                                             : err_count_q + ERR_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ACQ;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            cand_dir_q  <= 1'b0;
            match_cnt_q <= 4'd0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            dir_q       <= 1'b0;
            step_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            if (g_valid) begin
                bin_out_q   <= w_bin;
                bin_valid_q <= 1'b1;
                prev_q      <= w_bin;
                have_prev_q <= 1'b1;
                if (have_prev_q) begin
                    case (state_q)
                        ACQ: begin
                            if (w_is_move) begin
                                cand_dir_q  <= w_step_up;
                                match_cnt_q <= match_cnt_d;
                                if (w_lock) begin
                                    state_q  <= TRACK;
                                    locked_q <= 1'b1;
                                    dir_q    <= w_step_up;
                                end
                            end else if (w_step == STEP_BAD) begin
                                match_cnt_q <= 4'd0;
                            end
                        end
                        TRACK: begin
                            if (w_track_err) begin
                                step_err_q  <= 1'b1;
                                err_count_q <= err_count_d;
                                state_q     <= ACQ;
                                locked_q    <= 1'b0;
                                match_cnt_q <= 4'd0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign locked    = locked_q;
    assign dir       = dir_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gray_seq_monitor                                             |
// | Brief    : Self-checking bench for gray_seq_monitor against a step model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_gray_seq_monitor;

    localparam int W    = 4;
    localparam int LC   = 2;
    localparam int EW   = 2;
    localparam int MOD  = 1 << W;
    localparam int EMAX = (1 << EW) - 1;
`ifdef GRAY_MON_HOLD_ERR_EN
    localparam bit HOLD_ERR = 1'b1;
`else
    localparam bit HOLD_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  g_in;
    logic          g_valid;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          locked;
    logic          dir;
    logic          step_err;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    gray_seq_monitor #(
        .WIDTH      (W),
        .LOCK_COUNT (LC),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .g_in      (g_in),
        .g_valid   (g_valid),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .locked    (locked),
        .dir       (dir),
        .step_err  (step_err),
        .err_count (err_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (expected registered outputs after the last edge)
    int m_bin, m_prev, m_match, m_err;
    bit m_bvalid, m_locked, m_dir, m_serr, m_have, m_cand;

    logic [W+EW+3:0] w_obs;
    logic [W+EW+3:0] m_exp;
    assign w_obs = {bin_out, bin_valid, locked, dir & locked, step_err, err_count};

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int from_gray(input int g);
        int b;
        b = 0;
        for (int i = 0; i < W; i++)
            b = b | ((^(g >> i) & 1) << i);
        return b;
    endfunction

    task automatic model_reset();
        m_bin = 0; m_prev = 0; m_match = 0; m_err = 0;
        m_bvalid = 0; m_locked = 0; m_dir = 0; m_serr = 0; m_have = 0; m_cand = 0;
    endtask

    task automatic model_sample(input int g);
        int b, d;
        bit up, ok;
        b = from_gray(g);
        m_bin = b; m_bvalid = 1; m_serr = 0;
        if (m_have) begin
            d = (b - m_prev + MOD) % MOD;
            if (!m_locked) begin
                if (d == 1 || d == MOD - 1) begin
                    up = (d == 1);
                    if (m_match > 0 && up == m_cand) m_match++;
                    else begin m_cand = up; m_match = 1; end
                    if (m_match >= LC) begin m_locked = 1; m_dir = up; end
                end else if (d != 0) begin
                    m_match = 0;
                end
            end else begin
                ok = (d == 1 && m_dir) || (d == MOD - 1 && !m_dir) || (d == 0 && !HOLD_ERR);
                if (!ok) begin
                    m_serr = 1;
                    if (m_err < EMAX) m_err++;
                    m_locked = 0;
                    m_match = 0;
                end
            end
        end
        m_prev = b;
        m_have = 1;
    endtask

    // Drives one cycle (value given in binary, sent as Gray) and advances the model.
    task automatic drive(input int bin, input bit v, input bit r);
        @(negedge clk);
        g_in    = W'(to_gray(bin));
        g_valid = v;
        rst     = r;
        @(posedge clk);
        if (!r) model_reset();
        else if (!v) begin m_bvalid = 0; m_serr = 0; end
        else model_sample(to_gray(bin));
        m_exp = {W'(m_bin), m_bvalid, m_locked, m_dir & m_locked, m_serr, EW'(m_err)};
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0);
        drive(9, 1, 0);
        n_cmp++;
        if (w_obs !== m_exp || w_obs !== '0) begin
            n_fail++;
            $display("FAIL reset: got %b required %b", w_obs, m_exp);
        end
    endtask

    task automatic test_up_lock();
        for (int i = 0; i < 4; i++) begin
            drive(i, 1, 1);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL up_lock[%0d]: got %b required %b", i, w_obs, m_exp);
            end
            if (i == 2) begin
                n_cmp++;
                if (locked !== 1'b1 || dir !== 1'b1) begin
                    n_fail++;
                    $display("FAIL up_lock_flag: got locked=%b dir=%b required 1 1", locked, dir);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 4; i <= MOD; i++) begin
            drive(i % MOD, 1, 1);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %b required %b", i, w_obs, m_exp);
            end
        end
        n_cmp++;
        if (step_err !== 1'b0 || bin_out !== '0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end: got err=%b bin=%0d locked=%b required 0 0 1",
                     step_err, bin_out, locked);
        end
    endtask

    task automatic test_bad_step();
        int seq [6] = '{0, 1, 2, 3, 5, 6};
        drive(0, 0, 0);
        foreach (seq[i]) begin
            drive(seq[i], 1, 1);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL bad_step[%0d]: got %b required %b", i, w_obs, m_exp);
            end
            if (i == 4) begin
                n_cmp++;
                if (step_err !== 1'b1 || err_count !== EW'(1)) begin
                    n_fail++;
                    $display("FAIL bad_step_err: got err=%b cnt=%0d required 1 1", step_err, err_count);
                end
            end
        end
        drive(7, 1, 1);
        n_cmp++;
        if (w_obs !== m_exp || locked !== 1'b1 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got %b required %b", w_obs, m_exp);
        end
    endtask

    task automatic test_down();
        int seq [5] = '{0, 15, 14, 13, 14};
        drive(0, 0, 0);
        foreach (seq[i]) begin
            drive(seq[i], 1, 1);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL down[%0d]: got %b required %b", i, w_obs, m_exp);
            end
            if (i == 3) begin
                n_cmp++;
                if (locked !== 1'b1 || dir !== 1'b0) begin
                    n_fail++;
                    $display("FAIL down_lock: got locked=%b dir=%b required 1 0", locked, dir);
                end
            end
        end
        n_cmp++;
        if (step_err !== 1'b1) begin
            n_fail++;
            $display("FAIL down_reverse: got step_err=%b required 1", step_err);
        end
    endtask

    task automatic test_hold();
        int seq [5] = '{0, 1, 2, 2, 3};
        drive(0, 0, 0);
        foreach (seq[i]) begin
            drive(seq[i], 1, 1);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %b required %b", i, w_obs, m_exp);
            end
            if (i == 3) begin
                n_cmp++;
                if (step_err !== HOLD_ERR) begin
                    n_fail++;
                    $display("FAIL hold_err: got %b required %b", step_err, HOLD_ERR);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int base;
        drive(0, 0, 0);
        base = 0;
        for (int e = 0; e < 5; e++) begin
            for (int k = 0; k < 4; k++) begin
                // three up samples lock, then a +3 jump is illegal
                base = (k == 3) ? (base + 3) % MOD : (base + 1) % MOD;
                drive(base, 1, 1);
                n_cmp++;
                if (w_obs !== m_exp) begin
                    n_fail++;
                    $display("FAIL saturate[%0d.%0d]: got %b required %b", e, k, w_obs, m_exp);
                end
            end
        end
        n_cmp++;
        if (err_count !== EW'(EMAX)) begin
            n_fail++;
            $display("FAIL saturate_cnt: got %0d required %0d", err_count, EMAX);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(i, 1, 1);
        drive(4, 1, 0);
        n_cmp++;
        if (w_obs !== '0 || w_obs !== m_exp) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required %b", w_obs, m_exp);
        end
    endtask

    task automatic test_random();
        int cur, k;
        bit up, v, r;
        cur = 0;
        up  = 1;
        drive(0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) up = ~up;
            k = $urandom_range(0, 99);
            v = 1; r = 1;
            if (k < 10)      v = 0;
            else if (k < 15) cur = cur;
            else if (k < 20) cur = (cur + $urandom_range(2, MOD - 2)) % MOD;
            else if (k < 23) cur = up ? (cur + MOD - 1) % MOD : (cur + 1) % MOD;
            else if (k < 24) r = 0;
            else             cur = up ? (cur + 1) % MOD : (cur + MOD - 1) % MOD;
            drive(cur, v, r);
            n_cmp++;
            if (w_obs !== m_exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b required %b", i, w_obs, m_exp);
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        g_valid = 1'b0;
        g_in    = '0;
        model_reset();
        m_exp   = '0;
        test_reset();
        test_up_lock();
        test_wrap();
        test_bad_step();
        test_down();
        test_hold();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
